// File: rtl/vm_pkg.sv
// Shared voting-machine definitions: frame constants, candidate count and the
// state types used by the result transmitter and its byte serializer.
package vm_pkg;

    localparam int unsigned VM_BYTE_W      = 8;
    localparam logic [7:0]  VM_HDR         = 8'hA5;
    localparam int unsigned VM_FRAME_BYTES = 6;
    localparam int unsigned VM_NUM_CAND    = 4;

    // Result transmitter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START_BIT,
        ST_DATA_BITS,
        ST_STOP_BIT,
        ST_NEXT,
        ST_DONE
    } vm_tx_state_t;

    // Byte serializer line phases
    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } vm_ser_phase_t;

    // Running frame checksum: 8-bit add, carry discarded
    function automatic logic [7:0] vm_csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// Ports:
//   clock, reset   - system clock, async active-high reset
//   load           - one-cycle request; the byte on data starts on the next edge
//   data[7:0]      - byte to send, captured on load
//   tx             - serial line, idles high
//   byte_done      - one-cycle pulse two cycles before the stop bit ends, so a
//                    registered load from the sequencer lands with zero gap
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);
    import vm_pkg::*;

    localparam int unsigned CNT_W         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // With at least 3 clocks per bit the third-to-last cycle of the byte is
    // inside the stop bit; with 2 it is the last cycle of data bit 7.
    localparam bit EARLY_IN_STOP          = (CLKS_PER_BIT >= 3);
    localparam logic [CNT_W-1:0] CNT_EARLY = EARLY_IN_STOP ? CNT_W'(CLKS_PER_BIT - 3) : CNT_LAST;

    vm_ser_phase_t    phase;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             pre_done;

    // Bit-period end and the cycle that precedes the byte_done pulse
    always_comb begin
        bit_end = (baud_cnt == CNT_LAST);
        if (EARLY_IN_STOP) begin
            pre_done = (phase == SER_STOP) && (baud_cnt == CNT_EARLY);
        end else begin
            pre_done = (phase == SER_DATA) && (bit_idx == 3'd7) && bit_end;
        end
    end

    // Baud counter, bit index and shift register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase     <= SER_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            byte_done <= 1'b0;
        end else if (load) begin
            phase     <= SER_START;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= data;
            tx        <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= pre_done;
            if (phase != SER_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end
            case (phase)
                SER_IDLE: begin
                    tx <= 1'b1;
                end
                SER_START: begin
                    if (bit_end) begin
                        phase <= SER_DATA;
                        tx    <= shreg[0];
                    end
                end
                SER_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            phase   <= SER_STOP;
                            bit_idx <= '0;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                end
                SER_STOP: begin
                    if (bit_end) begin
                        phase <= SER_IDLE;
                    end
                end
                default: begin
                    phase <= SER_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/vote_result_tx.sv
// Voting machine result transmitter. On start in result mode it snapshots the
// four tallies and sends A5, count1..count4, checksum as UART 8N1 on tx.
// Ports:
//   clock, reset      - system clock, async active-high reset
//   mode              - 1 = result mode; requests accepted only then
//   start             - transmission request, sampled on the rising edge
//   count1..count4    - candidate tallies
//   tx                - UART line, idles high
//   busy              - high from frame acceptance to end of last stop bit
//   done              - one-cycle pulse after the frame completes
module vote_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       start,
    input  logic [7:0] count1,
    input  logic [7:0] count2,
    input  logic [7:0] count3,
    input  logic [7:0] count4,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    import vm_pkg::*;

    localparam int unsigned CNT_W         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BYTE      = 3'(VM_FRAME_BYTES - 1);

    vm_tx_state_t         state;
    logic [VM_BYTE_W-1:0] snap [VM_NUM_CAND];
    logic [VM_BYTE_W-1:0] csum;
    logic [VM_BYTE_W-1:0] data;
    logic [2:0]           byte_idx;
    logic [2:0]           bit_idx;
    logic [CNT_W-1:0]     baud_cnt;
    logic                 load;
    logic                 byte_done;
    logic [2:0]           next_idx;
    logic [VM_BYTE_W-1:0] next_tally;

    // Tally feeding byte n+1 is snapshot entry n
    always_comb begin
        next_idx   = byte_idx + 3'd1;
        next_tally = snap[byte_idx[1:0]];
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .data     (data),
        .tx       (tx),
        .byte_done(byte_done)
    );

    // Byte sequencing, snapshot and checksum. The next byte is handed to the
    // serializer on byte_done so its start bit follows the stop bit directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            for (int i = 0; i < int'(VM_NUM_CAND); i++) begin
                snap[i] <= '0;
            end
            csum     <= '0;
            data     <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            load     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && mode && !busy) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    snap[0]  <= count1;
                    snap[1]  <= count2;
                    snap[2]  <= count3;
                    snap[3]  <= count4;
                    csum     <= VM_HDR;
                    data     <= VM_HDR;
                    load     <= 1'b1;
                    busy     <= 1'b1;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                    state    <= ST_START_BIT;
                end
                ST_START_BIT: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA_BITS;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA_BITS: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= ST_STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP_BIT: begin
                    if (byte_done) begin
                        state <= ST_NEXT;
                        if (byte_idx != LAST_BYTE) begin
                            load <= 1'b1;
                            if (next_idx == LAST_BYTE) begin
                                data <= csum;
                            end else begin
                                data <= next_tally;
                                csum <= vm_csum_add(csum, next_tally);
                            end
                        end
                    end
                end
                ST_NEXT: begin
                    if (byte_idx == LAST_BYTE) begin
                        byte_idx <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        byte_idx <= next_idx;
                        state    <= ST_START_BIT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_result_tx.sv
// Testbench for vote_result_tx: timeline model of the expected line, busy and
// done per cycle, a UART decoder for the sent bytes, and directed scenarios.
module tb_vote_result_tx;

    localparam int CPB       = 10;
    localparam int FRAME_CYC = 60 * CPB;

    logic       clock;
    logic       reset;
    logic       mode;
    logic       start;
    logic [7:0] count1, count2, count3, count4;
    logic       tx, busy, done;

    int checks   = 0;
    int failures = 0;

    vote_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .mode  (mode),
        .start (start),
        .count1(count1),
        .count2(count2),
        .count3(count3),
        .count4(count4),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model: one frame record, timeline from acceptance edge
    int         cyc = 0;
    bit         m_have = 1'b0;
    int         m_k = 0;
    logic [7:0] m_bytes [6];
    bit         cmp_en = 1'b0;

    always @(posedge clock) begin
        int sum;
        cyc++;
        if (reset) begin
            m_have = 1'b0;
        end else begin
            if (m_have && cyc == m_k + 1) begin
                m_bytes[0] = 8'hA5;
                m_bytes[1] = count1;
                m_bytes[2] = count2;
                m_bytes[3] = count3;
                m_bytes[4] = count4;
                sum = (165 + int'(count1) + int'(count2) + int'(count3) + int'(count4)) % 256;
                m_bytes[5] = 8'(sum);
            end
            if (mode && start && (!m_have || cyc >= m_k + FRAME_CYC + 4)) begin
                m_have = 1'b1;
                m_k    = cyc;
            end
        end
    end

    function automatic logic exp_busy();
        return m_have && (cyc >= m_k + 1) && (cyc < m_k + 2 + FRAME_CYC);
    endfunction

    function automatic logic exp_done();
        return m_have && (cyc == m_k + 2 + FRAME_CYC);
    endfunction

    function automatic logic exp_tx();
        int off, bidx, pos;
        logic [7:0] b;
        if (!m_have || cyc < m_k + 2 || cyc >= m_k + 2 + FRAME_CYC) return 1'b1;
        off  = cyc - (m_k + 2);
        bidx = off / (10 * CPB);
        pos  = (off % (10 * CPB)) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = m_bytes[bidx];
        return b[pos-1];
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            chk("cyc_tx", 32'(tx), 32'(exp_tx()));
            chk("cyc_busy", 32'(busy), 32'(exp_busy()));
            chk("cyc_done", 32'(done), 32'(exp_done()));
        end
    end

    // ---------------- UART decoder and event counters
    logic [7:0] rx_q [$];
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte;
    int         done_total = 0;
    int         busy_total = 0;

    always @(negedge clock) begin
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                rx_byte[rx_cnt / CPB - 1] = tx;
            end
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                chk("rx_stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
        if (!reset && done === 1'b1) done_total++;
        if (!reset && busy === 1'b1) busy_total++;
    end

    // ---------------- stimulus helpers
    task automatic set_counts(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        count1 = a; count2 = b; count3 = c; count4 = d;
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", tag, budget);
        end
    endtask

    task automatic expect_frame(input string tag, input int base,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        logic [7:0] e [6];
        e = '{b0, b1, b2, b3, b4, b5};
        for (int i = 0; i < 6; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base + i]), 32'(e[i]));
            else
                chk($sformatf("%s_byte%0d_missing", tag, i), 32'(rx_q.size()), 32'(base + 6));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios
    initial begin
        int base, d0, b0, at1, at2, tfall;
        reset = 1'b0; mode = 1'b0; start = 1'b0;
        set_counts(8'h00, 8'h00, 8'h00, 8'h00);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clock);

        // Basic frame 2/2/2/2
        mode = 1'b1;
        set_counts(8'h02, 8'h02, 8'h02, 8'h02);
        base = rx_q.size(); d0 = done_total; b0 = busy_total;
        pulse_start();
        wait_done("t1", FRAME_CYC + 20, at1);
        repeat (3) @(negedge clock);
        expect_frame("t1", base, 8'hA5, 8'h02, 8'h02, 8'h02, 8'h02, 8'hAD);
        chk("t1_model_csum", 32'(m_bytes[5]), 32'hAD);
        chk("t1_busy_cycles", 32'(busy_total - b0), 32'(FRAME_CYC + 1));
        chk("t1_done_count", 32'(done_total - d0), 32'd1);

        // Checksum wrap: A5+FF+FF+FF+01 = 0x3A3 -> A3
        set_counts(8'hFF, 8'hFF, 8'hFF, 8'h01);
        base = rx_q.size();
        pulse_start();
        wait_done("t2", FRAME_CYC + 20, at1);
        repeat (3) @(negedge clock);
        expect_frame("t2", base, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hA3);
        chk("t2_model_csum", 32'(m_bytes[5]), 32'hA3);

        // Start outside result mode is ignored
        mode = 1'b0;
        base = rx_q.size(); d0 = done_total; b0 = busy_total;
        pulse_start();
        repeat (40) @(negedge clock);
        chk("t3_no_bytes", 32'(rx_q.size() - base), 32'd0);
        chk("t3_no_done", 32'(done_total - d0), 32'd0);
        chk("t3_no_busy", 32'(busy_total - b0), 32'd0);

        // Mid-frame tally change and ignored restart
        mode = 1'b1;
        set_counts(8'h0A, 8'h14, 8'h04, 8'h1E);
        base = rx_q.size(); d0 = done_total;
        pulse_start();
        repeat (200) @(negedge clock);
        count3 = 8'h09;
        pulse_start();
        wait_done("t4", FRAME_CYC, at1);
        repeat (40) @(negedge clock);
        expect_frame("t4", base, 8'hA5, 8'h0A, 8'h14, 8'h04, 8'h1E, 8'hE5);
        chk("t4_single_frame", 32'(rx_q.size() - base), 32'd6);
        chk("t4_done_count", 32'(done_total - d0), 32'd1);

        // Reset during byte 2 data bits (count2 = 0 keeps the line low there)
        set_counts(8'h33, 8'h00, 8'h44, 8'h55);
        base = rx_q.size(); d0 = done_total;
        pulse_start();
        repeat (242) @(negedge clock);
        chk("t5_tx_low_before_reset", 32'(tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("t5_tx_async_high", 32'(tx), 32'd1);
        chk("t5_busy_async_low", 32'(busy), 32'd0);
        chk("t5_partial_bytes", 32'(rx_q.size() - base), 32'd2);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("t5_no_done_after_reset", 32'(done_total - d0), 32'd0);
        chk("t5_no_resume", 32'(rx_q.size() - base), 32'd2);
        base = rx_q.size();
        pulse_start();
        wait_done("t5", FRAME_CYC + 20, at1);
        repeat (3) @(negedge clock);
        expect_frame("t5", base, 8'hA5, 8'h33, 8'h00, 8'h44, 8'h55, 8'h71);

        // Start held high: back-to-back frames
        set_counts(8'h01, 8'h02, 8'h03, 8'h04);
        base = rx_q.size(); d0 = done_total;
        @(negedge clock); start = 1'b1;
        wait_done("t6a", FRAME_CYC + 20, at1);
        tfall = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx === 1'b0) begin
                tfall = cyc;
                break;
            end
        end
        chk("t6_gap_done_to_start", 32'(tfall - at1), 32'd4);
        wait_done("t6b", FRAME_CYC + 20, at2);
        start = 1'b0;
        chk("t6_frame_period", 32'(at2 - at1), 32'(FRAME_CYC + 4));
        repeat (40) @(negedge clock);
        expect_frame("t6a", base, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAF);
        expect_frame("t6b", base + 6, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAF);
        chk("t6_done_count", 32'(done_total - d0), 32'd2);
        chk("t6_byte_count", 32'(rx_q.size() - base), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
